// File: rtl/servant_gpio_pkg.sv
// Shared definitions for the servant GPIO controller: register offsets,
// debounce state encoding and default timing parameters.
package servant_gpio_pkg;

  localparam int unsigned DEB_CYCLES_DEF = 16;
  localparam int unsigned BLINK_DIV_DEF  = 1024;

  localparam logic [1:0] ADR_LED   = 2'd0;
  localparam logic [1:0] ADR_BLINK = 2'd1;
  localparam logic [1:0] ADR_BTN   = 2'd2;
  localparam logic [1:0] ADR_IRQ   = 2'd3;

  typedef enum logic {
    DEB_STABLE = 1'b0,
    DEB_COUNT  = 1'b1
  } deb_state_e;

endpackage

// File: rtl/servant_gpio_ctrl_if.sv
// Wishbone-style register bus between a master and the GPIO controller.
interface servant_gpio_ctrl_if;
  logic [31:0] i_wb_adr;
  logic [31:0] i_wb_dat;
  logic        i_wb_we;
  logic        i_wb_cyc;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;

  modport master (
    output i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc,
    input  o_wb_rdt, o_wb_ack
  );

  modport slave (
    input  i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc,
    output o_wb_rdt, o_wb_ack
  );
endinterface

// File: rtl/servant_gpio_debounce.sv
// One button: 2-flop synchronizer followed by a STABLE/COUNT debounce FSM.
// The debounced value changes only after the synchronized input has
// disagreed with it continuously until the counter reaches DEB_CYCLES-1.
module servant_gpio_debounce
  import servant_gpio_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic sync_o,
  output logic deb_o
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  deb_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          deb_q;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[0], btn_i};
  end

  // Debounce FSM with its counter and the registered debounced value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DEB_STABLE;
      cnt_q   <= '0;
      deb_q   <= 1'b0;
    end else begin
      case (state_q)
        DEB_STABLE: begin
          if (sync_q[1] != deb_q) begin
            state_q <= DEB_COUNT;
            cnt_q   <= '0;
          end
        end
        DEB_COUNT: begin
          if (sync_q[1] == deb_q) begin
            state_q <= DEB_STABLE;
          end else if (cnt_q == CNT_LAST) begin
            deb_q   <= sync_q[1];
            state_q <= DEB_STABLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= DEB_STABLE;
      endcase
    end
  end

  assign sync_o = sync_q[1];
  assign deb_o  = deb_q;

endmodule

// File: rtl/servant_gpio_ctrl.sv
// Servant GPIO controller: 4 LEDs with per-LED blink, 3 debounced buttons
// and an optional rising-edge interrupt block.
// Optional feature macro: SERVANT_GPIO_IRQ_EN (edge capture, IRQ register,
// o_irq). Without it the IRQ register reads 0 and o_irq is tied low.
module servant_gpio_ctrl
  import servant_gpio_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned BLINK_DIV  = BLINK_DIV_DEF
) (
  input  logic                i_wb_clk,
  input  logic                i_wb_rst_n,
  servant_gpio_ctrl_if.slave  wb,
  output logic [3:0]          o_led,
  input  logic [2:0]          i_buttons,
  output logic                o_irq
);

  localparam int unsigned PW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(BLINK_DIV - 1);

  logic [1:0]    sel;
  logic          go;
  logic          wr;
  logic          ack_q;
  logic [31:0]   rdt_q;
  logic [31:0]   rdt_d;
  logic [3:0]    led_q;
  logic [3:0]    blink_q;
  logic [PW-1:0] pcnt_q;
  logic          phase_q;
  logic [3:0]    led_out_q;
  logic [2:0]    btn_sync;
  logic [2:0]    btn_deb;
  logic [31:0]   irq_rd;
  logic          unused_bits;

  assign sel = wb.i_wb_adr[3:2];
  assign go  = wb.i_wb_cyc & ~ack_q;
  assign wr  = go & wb.i_wb_we;
  assign unused_bits = ^{wb.i_wb_adr[31:4], wb.i_wb_adr[1:0], wb.i_wb_dat[31:7]};

  for (genvar g = 0; g < 3; g++) begin : g_btn
    servant_gpio_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk_i  (i_wb_clk),
      .rst_ni (i_wb_rst_n),
      .btn_i  (i_buttons[g]),
      .sync_o (btn_sync[g]),
      .deb_o  (btn_deb[g])
    );
  end

`ifdef SERVANT_GPIO_IRQ_EN
  logic [2:0] pend_q;
  logic [2:0] en_q;
  logic [2:0] prev_q;
  logic [2:0] arm_q;
  logic [1:0] settle_q;
  logic       irq_q;
  logic [2:0] rise;
  logic [2:0] clr;

  // Rising edges of armed buttons, and W1C mask from an IRQ write.
  always_comb begin
    rise = btn_deb & ~prev_q & arm_q;
    clr  = '0;
    if (wr && (sel == ADR_IRQ)) clr = wb.i_wb_dat[2:0];
  end

  assign irq_rd = {25'd0, en_q, 1'b0, pend_q};

  // Edge capture, pending/enable registers and the registered interrupt.
  // A button is armed only once its synchronized input has been seen low
  // after the synchronizer refilled, so buttons held through reset release
  // never report an edge.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      pend_q   <= '0;
      en_q     <= '0;
      prev_q   <= '0;
      arm_q    <= '0;
      settle_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      prev_q <= btn_deb;
      if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
      else                  arm_q    <= arm_q | ~btn_sync;
      pend_q <= (pend_q & ~clr) | rise;
      if (wr && (sel == ADR_IRQ)) en_q <= wb.i_wb_dat[6:4];
      irq_q <= |(pend_q & en_q);
    end
  end

  assign o_irq = irq_q;
`else
  logic unused_irq;

  assign irq_rd     = '0;
  assign o_irq      = 1'b0;
  assign unused_irq = ^{btn_sync, wb.i_wb_dat[6:4]};
`endif

  // Read data mux over the current register contents.
  always_comb begin
    rdt_d = '0;
    case (sel)
      ADR_LED:   rdt_d = {28'd0, led_q};
      ADR_BLINK: rdt_d = {28'd0, blink_q};
      ADR_BTN:   rdt_d = {29'd0, btn_deb};
      ADR_IRQ:   rdt_d = irq_rd;
      default:   rdt_d = '0;
    endcase
  end

  // Bus handshake, read data capture and LED/BLINK register writes.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      ack_q   <= 1'b0;
      rdt_q   <= '0;
      led_q   <= '0;
      blink_q <= '0;
    end else begin
      ack_q <= go;
      if (go) rdt_q <= rdt_d;
      if (wr && (sel == ADR_LED))   led_q   <= wb.i_wb_dat[3:0];
      if (wr && (sel == ADR_BLINK)) blink_q <= wb.i_wb_dat[3:0];
    end
  end

  // Blink prescaler: free-running while any blink bit is set, parked otherwise.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      pcnt_q  <= '0;
      phase_q <= 1'b1;
    end else if (blink_q == '0) begin
      pcnt_q  <= '0;
      phase_q <= 1'b1;
    end else if (pcnt_q == PCNT_LAST) begin
      pcnt_q  <= '0;
      phase_q <= ~phase_q;
    end else begin
      pcnt_q <= pcnt_q + 1'b1;
    end
  end

  // Registered LED drive, gated by the blink phase for blinking LEDs.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) led_out_q <= '0;
    else             led_out_q <= led_q & (~blink_q | {4{phase_q}});
  end

  assign wb.o_wb_ack = ack_q;
  assign wb.o_wb_rdt = rdt_q;
  assign o_led       = led_out_q;

endmodule
